// File: rtl/joy_serializer.sv
// joy_serializer: board-side transmitter for the joydecoder serial link.
// It presents two active-low 6-button joysticks as a 16-bit frame and
// shifts the frame out on joy_data. joy_clk and joy_load come from the host
// and are oversampled on clk_sys. The link behaves like a 74HC165 chain
// with serial-in tied high.
// Optional feature: define JOYSER_DEBOUNCE_EN to add a per-button stability
// filter of DEB_CYCLES cycles. By default each button passes through one
// register stage.
module joy_serializer #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [23:0] IDLE_CYCLES = 24'd4_800_000,
  parameter logic [15:0] DEB_CYCLES  = 16'd48_000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       joy_clk,
  input  logic       joy_load,
  input  logic [5:0] joy1_n,
  input  logic [5:0] joy2_n,
  output logic       joy_data,
  output logic [7:0] frame_cnt,
  output logic       overrun,
  output logic       link_idle
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  // The frame is built from 16 button/pad bits. A zero stability time would
  // make the filter meaningless.
  if (WIDTH < 16 || DEB_CYCLES == 16'd0) begin : g_bad_cfg
    $error("joy_serializer: WIDTH must be >= 16 and DEB_CYCLES nonzero");
  end

  // Bits [1:0] are the two synchroniser stages and bit [2] is the edge-detect delay.
  logic [2:0] clk_sync;
  logic [2:0] load_sync;
  logic       clk_s;
  logic       load_s;
  logic       clk_rise;
  logic       load_rise;

  // Filtered button state, {joy1, joy2}, active low.
  logic [11:0] btn_f;

  logic [15:0]       frame_word;
  logic [WIDTH-1:0]  load_word;
  logic [WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]  shift_cnt;
  logic [23:0]       idle_cnt;

  // Double-flop synchronise host link signals and keep one delay stage for edges.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      load_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], joy_clk};
      load_sync <= {load_sync[1:0], joy_load};
    end
  end

  assign clk_s     = clk_sync[1];
  assign load_s    = load_sync[1];
  assign clk_rise  = clk_sync[1] & ~clk_sync[2];
  assign load_rise = load_sync[1] & ~load_sync[2];

`ifdef JOYSER_DEBOUNCE_EN
  logic [11:0] btn_raw;

  // Register the raw buttons once before the filter counters see them.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_raw <= '1;
    end else begin
      btn_raw <= {joy1_n, joy2_n};
    end
  end

  for (genvar g = 0; g < 12; g++) begin : g_deb
    logic [15:0] deb_cnt;

    // Accept a new button level only after it has differed from the filtered
    // level for DEB_CYCLES consecutive cycles. Any return resets the run.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        deb_cnt  <= '0;
        btn_f[g] <= 1'b1;
      end else if (btn_raw[g] == btn_f[g]) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= DEB_CYCLES - 16'd1) begin
        deb_cnt  <= '0;
        btn_f[g] <= btn_raw[g];
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end
`else
  // Single register stage on the buttons, reset to released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_f <= '1;
    end else begin
      btn_f <= {joy1_n, joy2_n};
    end
  end
`endif

  assign frame_word = {btn_f[11:6], 2'b11, btn_f[5:0], 2'b11};

  // The frame occupies the top of the register. Any extra length reads as released.
  always_comb begin
    load_word = '1;
    load_word[WIDTH-1 -: 16] = frame_word;
  end

  // Shift register and shift count. While load is low the register reloads,
  // so a joy_clk edge in that cycle is ignored.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '1;
      shift_cnt <= '0;
      overrun   <= 1'b0;
    end else if (!load_s) begin
      shift_reg <= load_word;
      shift_cnt <= '0;
    end else if (clk_rise) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b1};
      if (shift_cnt == CNT_FULL) begin
        overrun <= 1'b1;
      end else begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end
  end

  // Register the serial output bit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_data <= 1'b1;
    end else begin
      joy_data <= shift_reg[WIDTH-1];
    end
  end

  // Count frames and re-arm the idle timer on each load release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      idle_cnt  <= '0;
    end else if (load_rise) begin
      frame_cnt <= frame_cnt + 8'd1;
      idle_cnt  <= IDLE_CYCLES;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 24'd1;
    end
  end

  assign link_idle = (idle_cnt == '0);

  // The synchronised shift-clock level itself drives nothing beyond edge detection.
  logic unused_clk_level;
  assign unused_clk_level = clk_s;

endmodule

// File: tb/tb_joy_serializer.sv
// Self-checking bench for joy_serializer. A host model drives joy_load and
// joy_clk slowly compared with clk_sys. The expected serial bits, frame
// count, overrun and idle state come from the link rules in plain arithmetic.
module tb_joy_serializer;

  localparam int unsigned W    = 16;
  localparam int unsigned IDLE = 300;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       joy_clk;
  logic       joy_load;
  logic [5:0] joy1_n;
  logic [5:0] joy2_n;
  logic       joy_data;
  logic [7:0] frame_cnt;
  logic       overrun;
  logic       link_idle;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frame_cnt_m;
  logic       overrun_m;
  int         edges_m;

  joy_serializer #(
    .WIDTH(W),
    .IDLE_CYCLES(24'(IDLE)),
    .DEB_CYCLES(16'd100)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .joy_clk(joy_clk),
    .joy_load(joy_load),
    .joy1_n(joy1_n),
    .joy2_n(joy2_n),
    .joy_data(joy_data),
    .frame_cnt(frame_cnt),
    .overrun(overrun),
    .link_idle(link_idle)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] frame_of(input logic [5:0] a, input logic [5:0] b);
    return {a, 2'b11, b, 2'b11};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Time for a button change to reach the frame register.
  task automatic settle();
`ifdef JOYSER_DEBOUNCE_EN
    wait_cycles(120);
`else
    wait_cycles(3);
`endif
  endtask

  task automatic host_load();
    joy_load = 1'b0;
    wait_cycles(8);
    joy_load = 1'b1;
    wait_cycles(8);
    frame_cnt_m = frame_cnt_m + 8'd1;
    edges_m = 0;
  endtask

  task automatic host_shift();
    joy_clk = 1'b1;
    wait_cycles(8);
    joy_clk = 1'b0;
    wait_cycles(8);
    edges_m++;
    if (edges_m > W) overrun_m = 1'b1;
  endtask

  // A load pulse followed by a number of shift edges, with each serial bit checked.
  task automatic run_frame(input logic [15:0] exp, input int shifts);
    logic expd;
    host_load();
    checks++;
    if (frame_cnt !== frame_cnt_m) begin
      failures++;
      $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, frame_cnt_m);
    end
    checks++;
    if (link_idle !== 1'b0) begin
      failures++;
      $display("FAIL link_idle_after_load got=%b exp=0", link_idle);
    end
    checks++;
    if (joy_data !== exp[15]) begin
      failures++;
      $display("FAIL data_bit0 got=%b exp=%b word=%h", joy_data, exp[15], exp);
    end
    for (int i = 1; i <= shifts; i++) begin
      host_shift();
      expd = (i < 16) ? exp[15-i] : 1'b1;
      checks++;
      if (joy_data !== expd) begin
        failures++;
        $display("FAIL data_bit%0d got=%b exp=%b word=%h", i, joy_data, expd, exp);
      end
      checks++;
      if (overrun !== overrun_m) begin
        failures++;
        $display("FAIL overrun_edge%0d got=%b exp=%b", i, overrun, overrun_m);
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    joy_clk  = 1'b0;
    joy_load = 1'b1;
    joy1_n   = '1;
    joy2_n   = '1;
    frame_cnt_m = '0;
    overrun_m   = 1'b0;
    edges_m     = 0;
    wait_cycles(3);
    checks++;
    if ({joy_data, frame_cnt, overrun, link_idle} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_in got=%b/%0d/%b/%b exp=1/0/0/1", joy_data, frame_cnt, overrun, link_idle);
    end
    reset_n = 1'b1;
    wait_cycles(5);
    checks++;
    if ({joy_data, frame_cnt, overrun, link_idle} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_out got=%b/%0d/%b/%b exp=1/0/0/1", joy_data, frame_cnt, overrun, link_idle);
    end
  endtask

  task automatic test_fixed_frame();
    joy1_n = 6'b111110;
    joy2_n = 6'b011111;
    settle();
    run_frame(16'b1111101101111111, 16);
    wait_cycles(20);
    checks++;
    if (joy_data !== 1'b1) begin
      failures++;
      $display("FAIL data_after_frame got=%b exp=1", joy_data);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      joy1_n = 6'($urandom);
      joy2_n = 6'($urandom);
      settle();
      run_frame(frame_of(joy1_n, joy2_n), 16);
    end
  endtask

  task automatic test_load_held();
    joy_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      joy1_n  = 6'($urandom);
      joy_clk = ~joy_clk;
`ifdef JOYSER_DEBOUNCE_EN
      wait_cycles(110);
`else
      wait_cycles(5);
`endif
      checks++;
      if (joy_data !== joy1_n[5]) begin
        failures++;
        $display("FAIL load_held%0d got=%b exp=%b", k, joy_data, joy1_n[5]);
      end
      wait_cycles(2);
    end
    joy_clk = 1'b0;
    wait_cycles(8);
    joy_load = 1'b1;
    wait_cycles(8);
    frame_cnt_m = frame_cnt_m + 8'd1;
    edges_m = 0;
    joy2_n = 6'($urandom);
    settle();
    run_frame(frame_of(joy1_n, joy2_n), 16);
  endtask

  task automatic test_overrun();
    joy1_n = 6'($urandom);
    joy2_n = 6'($urandom);
    settle();
    run_frame(frame_of(joy1_n, joy2_n), 17);
    joy1_n = 6'($urandom);
    settle();
    run_frame(frame_of(joy1_n, joy2_n), 16);
  endtask

  task automatic test_idle();
    host_load();
    wait_cycles(280);
    checks++;
    if (link_idle !== 1'b0) begin
      failures++;
      $display("FAIL idle_early got=%b exp=0", link_idle);
    end
    wait_cycles(20);
    checks++;
    if (link_idle !== 1'b1) begin
      failures++;
      $display("FAIL idle_expired got=%b exp=1", link_idle);
    end
    joy_load = 1'b0;
    wait_cycles(8);
    joy_load = 1'b1;
    frame_cnt_m = frame_cnt_m + 8'd1;
    edges_m = 0;
    wait_cycles(2);
    checks++;
    if (link_idle !== 1'b1) begin
      failures++;
      $display("FAIL idle_before_detect got=%b exp=1", link_idle);
    end
    wait_cycles(3);
    checks++;
    if (link_idle !== 1'b0 || frame_cnt !== frame_cnt_m) begin
      failures++;
      $display("FAIL idle_rearm got=%b/%0d exp=0/%0d", link_idle, frame_cnt, frame_cnt_m);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    joy1_n = 6'($urandom);
    joy2_n = 6'($urandom);
    settle();
    w = frame_of(joy1_n, joy2_n);
    host_load();
    for (int i = 1; i <= 7; i++) host_shift();
    checks++;
    if (joy_data !== w[8]) begin
      failures++;
      $display("FAIL midframe_bit7 got=%b exp=%b", joy_data, w[8]);
    end
    reset_n = 1'b0;
    #1;
    frame_cnt_m = '0;
    overrun_m   = 1'b0;
    edges_m     = 0;
    checks++;
    if ({joy_data, frame_cnt, overrun, link_idle} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d/%b/%b exp=1/0/0/1", joy_data, frame_cnt, overrun, link_idle);
    end
    wait_cycles(3);
    reset_n = 1'b1;
    joy1_n = 6'($urandom);
    joy2_n = 6'($urandom);
    settle();
    run_frame(frame_of(joy1_n, joy2_n), 16);
  endtask

`ifdef JOYSER_DEBOUNCE_EN
  task automatic test_debounce();
    joy1_n = '1;
    joy2_n = 6'($urandom);
    settle();
    joy1_n[1] = 1'b0;
    wait_cycles(50);
    joy1_n[1] = 1'b1;
    settle();
    run_frame(frame_of(6'b111111, joy2_n), 16);
    joy1_n[1] = 1'b0;
    wait_cycles(150);
    run_frame(frame_of(6'b111101, joy2_n), 16);
    joy1_n = '1;
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_frame();
    test_random_frames();
    test_load_held();
    test_overrun();
    test_idle();
    test_reset_midframe();
`ifdef JOYSER_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
